// File: rtl/rns_modadd_seq.sv
// Nibble-serial modular adder: (a + b) mod m on W = 4*NIB-bit residues.
// One 4-bit CLA slice is time-shared across an add pass and a trial-subtract pass.

module rns_modadd_cla4 (
  input  logic       cin_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] s_o,
  output logic       cout_o
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s_o    = p ^ c[3:0];
  assign cout_o = c[4];
endmodule

module rns_modadd_seq #(
  parameter int NIB = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4*NIB-1:0] a_i,
  input  logic [4*NIB-1:0] b_i,
  input  logic [4*NIB-1:0] m_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [4*NIB-1:0] result_o
);
  localparam int W  = 4 * NIB;
  localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, ADD, SUB, FIN} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic          c1_q, c1_d, c2_q, c2_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, m_q, m_d;
  logic [W-1:0]  sum_q, sum_d, diff_q, diff_d, res_q, res_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic [3:0] sl_a, sl_b, sl_s;
  logic       sl_co;
  logic       last;

  // SUB adds ~m with carry-in 1, i.e. subtracts m two's-complement style.
  assign sl_a = (state_q == SUB) ? sum_q[k_q*4 +: 4] : a_q[k_q*4 +: 4];
  assign sl_b = (state_q == SUB) ? ~m_q[k_q*4 +: 4] : b_q[k_q*4 +: 4];
  assign last = (k_q == K_LAST);

  rns_modadd_cla4 u_cla (
    .cin_i (carry_q),
    .a_i   (sl_a),
    .b_i   (sl_b),
    .s_o   (sl_s),
    .cout_o(sl_co)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    sum_d   = sum_q;
    diff_d  = diff_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          m_d     = m_i;
          k_d     = '0;
          carry_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[k_q*4 +: 4] = sl_s;
        carry_d = sl_co;
        k_d     = k_q + 1'b1;
        if (last) begin
          c1_d    = sl_co;
          k_d     = '0;
          carry_d = 1'b1;
          state_d = SUB;
        end
      end
      SUB: begin
        diff_d[k_q*4 +: 4] = sl_s;
        carry_d = sl_co;
        k_d     = k_q + 1'b1;
        if (last) begin
          // Either a carry out of the add or no borrow on subtract means S >= m.
          c2_d    = sl_co;
          k_d     = '0;
          res_d   = (c1_q | sl_co) ? diff_d : sum_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      sum_q   <= '0;
      diff_q  <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      sum_q   <= sum_d;
      diff_q  <= diff_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = res_q;
endmodule

// File: doc/rns_modadd_seq.md
# rns_modadd_seq

Nibble-serial modular adder controller for the RNS channel datapath. It time-shares one 4-bit carry-lookahead adder slice (cin, a[3:0], b[3:0] -> result[3:0], cout) to compute (a + b) mod m on W = 4*NIB-bit residues. It makes two passes: an add pass, then a trial-subtract pass. It sits between the channel operand registers and the residue writeback, one instance per modulus channel.

## Interface
Parameters:
- NIB, default 4: nibbles per operand; W = 4*NIB. Legal range 1..8.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only when busy = 0.
- a  in  W  addend. Requires a < m. Latched on an accepted start.
- b  in  W  addend. Requires b < m. Latched on an accepted start.
- m  in  W  modulus. Requires m != 0. Latched on an accepted start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: result updated this cycle.
- result  out  W  (a + b) mod m. Held from the done cycle until the next done pulse.

## Operation
- Single instance of the 4-bit CLA slice. Nibble index k counts 0..NIB-1, LSB nibble first. A 1-bit registered carry links the nibble steps.
- States: IDLE, ADD, SUB, FIN.
- IDLE / FIN, start=1: latch a, b, m. Set k=0 and carry=0. Go to ADD.
- IDLE / FIN, start=0: go to or stay in IDLE.
- ADD: slice inputs are cin=carry, a_nib[k], b_nib[k]. The slice result is written to sum nibble k, and carry takes cout.
  - At k = NIB-1, store the final cout as c1, set k=0, preset carry=1, and go to SUB.
- SUB: slice inputs are cin=carry, sum_nib[k], ~m_nib[k]. The slice result is written to diff nibble k, and carry takes cout.
  - At k = NIB-1, store the final cout as c2.
  - result <= (c1 | c2) ? diff : sum.
  - done <= 1. Go to FIN.
- FIN lasts one cycle: done=1, busy=0. The next state follows the IDLE rules.
- Arithmetic:
  - Full sum S = c1*2^W + sum.
  - c2 = 1 iff sum >= m. c1 = 1 implies S > m.
  - diff = (sum - m) mod 2^W, which is exact whenever it is selected.
  - Exact equality S = m yields result 0.
- Precondition violations (a >= m, b >= m, m = 0) give an unspecified result. The FSM timing is unchanged.
- start while busy=1 is ignored. Latched operands do not change mid-operation.
- Simultaneous rst and start: rst wins.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, result=0.
  - k=0, carry=0, c1=0, c2=0.
  - sum, diff, and the operand latches are all 0.
- Cycle numbering: start is accepted at edge 0.
  - busy=1 in cycles 1..2*NIB.
  - ADD occupies cycles 1..NIB.
  - SUB occupies cycles NIB+1..2*NIB.
  - done=1 and the new result are visible in cycle 2*NIB+1 (9 cycles for NIB=4).
- Throughput: one operation per 2*NIB+1 cycles. A start held high during FIN is accepted, which gives back-to-back operation with no idle gap.
- busy and done are never high together.
- rst mid-operation: the next cycle shows IDLE, busy=0, done=0, result=0. Any partial operation is discarded.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Default parameters (NIB=4, W=16) unless stated.
- No wrap: a=0x1234, b=0x2345, m=0xFFF1, pulse start -> busy in cycles 1..8, done in cycle 9, result=0x3579 (sum < m path).
- Carry-out path: a=0xFFF0, b=0xFFF0, m=0xFFF1 -> result=0xFFEF (c1=1, diff selected).
- Exact modulus: a=0x8000, b=0x7FF1, m=0xFFF1 -> result=0x0000 (c2=1 with diff=0). Also NIB=1, a=5, b=6, m=7 -> result=4 at cycle 3.
- Back-to-back and ignored start:
  - Hold start=1 continuously with a=1, b=2, m=0x0010 -> done pulses at cycles 9 and 18, result=3.
  - Change a/b while busy -> result is unaffected.
  - A start pulse in cycle 4 -> ignored.
- Reset mid-op: start, then rst=1 in cycle 5 -> cycle 6 shows busy=0, done=0, result=0. A new start then completes normally with the correct value.
- Random sweep: 10k random m in [1, 0xFFFF] with a, b < m, compared against a reference (a+b)%m. Check the done-cycle spacing and that busy and done are never both high.
